// File: rtl/sobol_pkg.sv
// Shared types and field positions for the Sobol Monte-Carlo pi estimator.
// Each 32-bit point word packs an unsigned Q0.16 x in the upper half and y in the lower half.
package sobol_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int PT_W     = 32;
   localparam int HALF_W   = 16;
   localparam int PIPE_LAT = 3;

   localparam int X_MSB = 31;
   localparam int X_LSB = 16;
   localparam int Y_MSB = 15;
   localparam int Y_LSB = 0;

endpackage

// File: rtl/sobol_pt_in_circle.sv
// Two-stage unit-circle test for one Q0.16 point: square both coordinates, then sum and compare.
// The inside flag is true when x*x + y*y < 2^32, i.e. the sum does not carry into bit 32.
module sobol_pt_in_circle
   import sobol_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_clr,
   input  logic              i_vld,
   input  logic [HALF_W-1:0] i_x,
   input  logic [HALF_W-1:0] i_y,
   output logic              o_vld_p1,
   output logic              o_vld_p2,
   output logic              o_inside_p2
);

   logic [PT_W-1:0] r_xs_p1;
   logic [PT_W-1:0] r_ys_p1;
   logic            r_vld_p1;
   logic            r_vld_p2;
   logic            r_inside_p2;
   logic [PT_W:0]   w_sum_p1;

   assign w_sum_p1 = {1'b0, r_xs_p1} + {1'b0, r_ys_p1};

   // Stage 1: squares, stage 2: sum and carry test
   always_ff @(posedge clk) begin
      r_xs_p1     <= PT_W'(i_x) * PT_W'(i_x);
      r_ys_p1     <= PT_W'(i_y) * PT_W'(i_y);
      r_inside_p2 <= ~w_sum_p1[PT_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else if (i_clr) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else begin
         r_vld_p1 <= i_vld;
         r_vld_p2 <= r_vld_p1;
      end
   end

   assign o_vld_p1    = r_vld_p1;
   assign o_vld_p2    = r_vld_p2;
   assign o_inside_p2 = r_inside_p2;

endmodule

// File: rtl/sobol_mc_pi_est.sv
// Counts inside-circle hits over N_GROUPS groups of four Sobol points and reports hit/total.
// Dropping start aborts any run; a new run needs start to go low and then high again.
module sobol_mc_pi_est
   import sobol_pkg::*;
#(
   parameter int N_GROUPS = 1024,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [PT_W-1:0]  pt0,
   input  logic [PT_W-1:0]  pt1,
   input  logic [PT_W-1:0]  pt2,
   input  logic [PT_W-1:0]  pt3,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] total_cnt
);

   localparam int GRP_W = $clog2(N_GROUPS + 1);

   if (CNT_W < $clog2(4 * N_GROUPS + 1)) begin : g_cnt_w_chk
      $error("CNT_W cannot hold 4*N_GROUPS");
   end

   state_t           r_state;
   logic [GRP_W-1:0] r_groups;
   logic             r_busy;
   logic             r_done;
   logic [CNT_W-1:0] r_hit;
   logic [CNT_W-1:0] r_tot;

   logic [PT_W-1:0]  w_pts [4];
   logic [3:0]       w_vld_p1;
   logic [3:0]       w_vld_p2;
   logic [3:0]       w_inside_p2;
   logic             w_accept;
   logic             w_pipe_busy;

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   assign w_pts[0] = pt0;
   assign w_pts[1] = pt1;
   assign w_pts[2] = pt2;
   assign w_pts[3] = pt3;

   assign w_accept    = (r_state == RUN) && in_valid && (r_groups < GRP_W'(N_GROUPS));
   assign w_pipe_busy = (|w_vld_p1) || (|w_vld_p2);

   for (genvar g = 0; g < 4; g++) begin : g_pt
      sobol_pt_in_circle u_pt (
         .clk         (clk),
         .rst_n       (rst_n),
         .i_clr       (~start),
         .i_vld       (w_accept),
         .i_x         (w_pts[g][X_MSB:X_LSB]),
         .i_y         (w_pts[g][Y_MSB:Y_LSB]),
         .o_vld_p1    (w_vld_p1[g]),
         .o_vld_p2    (w_vld_p2[g]),
         .o_inside_p2 (w_inside_p2[g])
      );
   end

   // Stage 3: accumulate, alongside the run-control state machine
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_groups <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hit    <= '0;
         r_tot    <= '0;
      end else if (!start) begin
         r_state  <= IDLE;
         r_groups <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hit    <= '0;
         r_tot    <= '0;
      end else begin
         if (w_vld_p2[0]) begin
            r_hit <= r_hit + CNT_W'(popcnt4(w_inside_p2));
            r_tot <= r_tot + CNT_W'(4);
         end
         case (r_state)
            IDLE: begin
               r_state <= RUN;
               r_busy  <= 1'b1;
            end
            RUN: begin
               if (w_accept) begin
                  r_groups <= r_groups + GRP_W'(1);
                  if (r_groups == GRP_W'(N_GROUPS - 1)) r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!w_pipe_busy) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign hit_cnt   = r_hit;
   assign total_cnt = r_tot;

endmodule

// File: tb/tb_sobol_mc_pi_est.sv
// Directed bench for sobol_mc_pi_est: one DUT per group count, shared point/valid inputs,
// separate start per DUT so only the instance under test runs.
module tb_sobol_mc_pi_est;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] pt0, pt1, pt2, pt3;
   logic        st  [5];
   logic        bsy [5];
   logic        dn  [5];
   logic [31:0] hit [5];
   logic [31:0] tot [5];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sobol_mc_pi_est #(.N_GROUPS(2), .CNT_W(32)) u_n2 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(in_valid),
      .pt0(pt0), .pt1(pt1), .pt2(pt2), .pt3(pt3),
      .busy(bsy[0]), .done(dn[0]), .hit_cnt(hit[0]), .total_cnt(tot[0]));

   sobol_mc_pi_est #(.N_GROUPS(1), .CNT_W(32)) u_n1 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(in_valid),
      .pt0(pt0), .pt1(pt1), .pt2(pt2), .pt3(pt3),
      .busy(bsy[1]), .done(dn[1]), .hit_cnt(hit[1]), .total_cnt(tot[1]));

   sobol_mc_pi_est #(.N_GROUPS(3), .CNT_W(32)) u_n3 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .in_valid(in_valid),
      .pt0(pt0), .pt1(pt1), .pt2(pt2), .pt3(pt3),
      .busy(bsy[2]), .done(dn[2]), .hit_cnt(hit[2]), .total_cnt(tot[2]));

   sobol_mc_pi_est #(.N_GROUPS(4), .CNT_W(32)) u_n4 (
      .clk(clk), .rst_n(rst_n), .start(st[3]), .in_valid(in_valid),
      .pt0(pt0), .pt1(pt1), .pt2(pt2), .pt3(pt3),
      .busy(bsy[3]), .done(dn[3]), .hit_cnt(hit[3]), .total_cnt(tot[3]));

   sobol_mc_pi_est #(.N_GROUPS(1024), .CNT_W(32)) u_n1024 (
      .clk(clk), .rst_n(rst_n), .start(st[4]), .in_valid(in_valid),
      .pt0(pt0), .pt1(pt1), .pt2(pt2), .pt3(pt3),
      .busy(bsy[4]), .done(dn[4]), .hit_cnt(hit[4]), .total_cnt(tot[4]));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic grp(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] d);
      in_valid = v;
      pt0 = a;
      pt1 = b;
      pt2 = c;
      pt3 = d;
      step();
   endtask

   task automatic begin_run(input int k);
      st[k] = 1'b1;
      step();
   endtask

   task automatic end_run(input int k);
      st[k]    = 1'b0;
      in_valid = 1'b0;
      step();
      chk("clr_done", dn[k], 0);
      chk("clr_hit", hit[k], 0);
   endtask

   task automatic wait_done(input int k, input int budget);
      int n;
      n = 0;
      while (dn[k] !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      chk("done_rise", dn[k], 1);
   endtask

   // Direct-form 2-D Sobol: dim 0 is van der Corput, dim 1 uses m_i = 1, 3, 5, 15, ...
   function automatic logic [31:0] sob(input int idx, input int dim);
      logic [31:0] v;
      logic [31:0] r;
      r = '0;
      v = 32'h8000_0000;
      for (int i = 0; i < 32; i++) begin
         if (idx[i]) r = r ^ v;
         v = (dim == 0) ? (v >> 1) : (v ^ (v >> 1));
      end
      return r;
   endfunction

   function automatic logic [31:0] sob_pt(input int idx);
      logic [31:0] sx;
      logic [31:0] sy;
      sx = sob(idx, 0);
      sy = sob(idx, 1);
      return {sx[31:16], sy[31:16]};
   endfunction

   function automatic int model_inside(input logic [31:0] w);
      longint x;
      longint y;
      x = longint'(w[31:16]);
      y = longint'(w[15:0]);
      return ((x * x + y * y) < 64'h1_0000_0000) ? 1 : 0;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] p [4];
      int          model_hits;
      real         est;
      logic        pi_ok;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      pt0 = '0; pt1 = '0; pt2 = '0; pt3 = '0;
      for (int k = 0; k < 5; k++) st[k] = 1'b0;
      repeat (3) step();
      chk("rst_busy", bsy[0], 0);
      chk("rst_done", dn[0], 0);
      chk("rst_hit", hit[0], 0);
      chk("rst_tot", tot[4], 0);
      rst_n = 1'b1;
      step();

      // all-zero points: every point inside, exact latency through DRAIN
      begin_run(0);
      grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      in_valid = 1'b0;
      chk("t1_busy_drain", bsy[0], 1);
      chk("t1_done_early0", dn[0], 0);
      step();
      chk("t1_hit_e1", hit[0], 4);
      chk("t1_done_early1", dn[0], 0);
      step();
      chk("t1_hit_e2", hit[0], 8);
      chk("t1_done_early2", dn[0], 0);
      step();
      chk("t1_done", dn[0], 1);
      chk("t1_busy_done", bsy[0], 0);
      chk("t1_tot", tot[0], 8);
      repeat (2) step();
      chk("t1_done_hold", dn[0], 1);
      chk("t1_hit_hold", hit[0], 8);
      end_run(0);
      chk("t1_clr_tot", tot[0], 0);

      // all-ones points: every point outside
      begin_run(0);
      grp(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      grp(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      grp(0, 32'h0, 32'h0, 32'h0, 32'h0);
      wait_done(0, 10);
      chk("t2_hit", hit[0], 0);
      chk("t2_tot", tot[0], 8);
      end_run(0);

      // boundary points around x*x + y*y = 2^32
      begin_run(1);
      grp(1, 32'hFFFF_0000, 32'hFFFF_016A, 32'hFFFF_016B, 32'hB504_B504);
      grp(0, 32'h0, 32'h0, 32'h0, 32'h0);
      wait_done(1, 10);
      chk("t3_hit", hit[1], 3);
      chk("t3_tot", tot[1], 4);
      end_run(1);

      // bubbles, then extra groups that must be ignored
      begin_run(2);
      grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(0, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(0, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("t4_busy_mid", bsy[2], 1);
      grp(0, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(0, 32'h0, 32'h0, 32'h0, 32'h0);
      wait_done(2, 10);
      chk("t4_hit", hit[2], 12);
      chk("t4_tot", tot[2], 12);
      grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(0, 32'h0, 32'h0, 32'h0, 32'h0);
      step();
      chk("t4_tot_after_done", tot[2], 12);
      end_run(2);

      // abort mid-run, then a clean restart
      begin_run(3);
      grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      st[3]    = 1'b0;
      in_valid = 1'b0;
      step();
      chk("t5_abort_busy", bsy[3], 0);
      chk("t5_abort_hit", hit[3], 0);
      chk("t5_abort_tot", tot[3], 0);
      step();
      chk("t5_abort_hit_later", hit[3], 0);
      begin_run(3);
      for (int i = 0; i < 4; i++) grp(1, 32'h0, 32'h0, 32'h0, 32'h0);
      grp(0, 32'h0, 32'h0, 32'h0, 32'h0);
      wait_done(3, 10);
      chk("t5_hit", hit[3], 16);
      chk("t5_tot", tot[3], 16);
      end_run(3);

      // full run of 4096 Sobol points
      model_hits = 0;
      begin_run(4);
      for (int g = 0; g < 1024; g++) begin
         for (int j = 0; j < 4; j++) begin
            p[j] = sob_pt(4 * g + j);
            model_hits += model_inside(p[j]);
         end
         grp(1, p[0], p[1], p[2], p[3]);
      end
      grp(0, 32'h0, 32'h0, 32'h0, 32'h0);
      wait_done(4, 10);
      chk("t6_hit", hit[4], 64'(model_hits));
      chk("t6_tot", tot[4], 4096);
      est   = 4.0 * real'(hit[4]) / 4096.0;
      pi_ok = ((est - 3.14159265358979) < 0.01) && ((3.14159265358979 - est) < 0.01);
      chk("t6_pi_tol", pi_ok, 1);
      end_run(4);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sobol_mc_pi_est.md
Name: sobol_mc_pi_est

Overview:
- Consumer stage placed directly after the Sobol point generator.
- Each cycle it takes the generator's four registered 32-bit words.
- Each word is one 2-D point: x = word[31:16], y = word[15:0], both unsigned Q0.16 fractions in [0,1).
- For each point it tests whether x²+y² < 1, counts inside-circle hits over a fixed number of groups, then raises done with hit and total counts. A downstream or host pi estimate is 4·hit/total.

Parameters:
- N_GROUPS, 1024, number of 4-point input groups per run (≥1).
- CNT_W, 32, width of the hit and total counters; must hold 4·N_GROUPS.
- PIPE_LAT, 3, fixed pipeline latency in cycles; a localparam, not user-settable.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run enable, same level signal that drives the generator. Low means clear/idle.
- in_valid  in  1  the pt0..pt3 inputs hold a new group; top level drives it as start delayed one cycle.
- pt0  in  32  point 0, {x,y}.
- pt1  in  32  point 1.
- pt2  in  32  point 2.
- pt3  in  32  point 3.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE.
- hit_cnt  out  CNT_W  inside-circle count.
- total_cnt  out  CNT_W  points evaluated, i.e. 4 × groups accepted.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, hit_cnt=0, total_cnt=0.
  - group counter=0.
  - All pipeline valid bits cleared.
- Per-point test:
  - S1: register xs=x·x and ys=y·y (32 bits each).
  - S2: register sum = xs+ys, 33 bits. inside = ~sum[32], so a point is inside iff sum < 2^32 (strict).
  - S3: add popcount of the four inside flags (0..4) to hit_cnt, and add 4 to total_cnt.
  - Counters update on the edge PIPE_LAT cycles after the in_valid edge.
- States:
  - IDLE: counters held at 0. On start=1, go to RUN next cycle.
  - RUN:
    - A group is accepted when in_valid=1 and groups_in < N_GROUPS.
    - When the N_GROUPS-th group is accepted, go to DRAIN next cycle.
    - in_valid after that point is ignored; no error flag.
  - DRAIN: wait until all pipeline valid bits are 0 (at most PIPE_LAT cycles), then go to DONE.
  - DONE: done=1. hit_cnt and total_cnt hold; further in_valid is ignored.
- Global conditions:
  - start=0 in any state: next cycle go to IDLE, clear counters and pipeline valids, busy=done=0. This is an abort mid-run; it mirrors the generator clearing its outputs.
  - start held high after DONE: stay in DONE. A new run needs start to go low then high.
  - in_valid=0 while in RUN: bubble. Nothing is counted and the state is held.
  - Counter wrap cannot occur by construction (CNT_W ≥ clog2(4·N_GROUPS+1)). An elaboration-time check enforces this.
  - in_valid while in IDLE is ignored.
- Outputs are registered. hit_cnt and total_cnt are stable whenever done=1.

Decomposition:
- Shared package sobol_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE).
  - PT_W=32 and HALF_W=16 constants.
  - The x/y field slice positions.
- One sub-module: sobol_pt_in_circle.
  - Per-point two-stage square/sum/compare, 16-bit inputs, 1-bit registered inside output with valid.
  - Instantiated 4×.
  - Popcount and accumulation stay in the top.

Test Plan:
1. Reset, then start=1 with N_GROUPS=2; feed two groups of all pt=32'h0000_0000 → done rises 3 cycles after the last group plus the DRAIN exit; hit_cnt=8, total_cnt=8.
2. Two groups of pt=32'hFFFF_FFFF (sum 8589672450) → hit_cnt=0, total_cnt=8.
3. Boundary, one group {32'hFFFF_0000, 32'hFFFF_016A, 32'hFFFF_016B, 32'hB504_B504}:
   - sums are 4294836225 (in), 4294967269 (in), 4294967994 (out), 4294791200 (in);
   - expect hit_cnt=3, total_cnt=4 (N_GROUPS=1).
4. Bubbles: N_GROUPS=3, in_valid pattern 1,0,0,1,0,1 with pt=0, followed by extra in_valid=1 groups → hit_cnt=12, total_cnt=12; extras are ignored.
5. Abort: N_GROUPS=4, start drops after 2 groups → next cycle busy=0, hit_cnt=0, total_cnt=0. Restart and run 4 groups of pt=0 → hit_cnt=16.
6. Integration with the Sobol generator, N_GROUPS=1024:
   - every output group is checked against a software model of the same direction numbers;
   - hit_cnt must equal the model count exactly;
   - 4·hit_cnt/4096 must lie within 0.01 of pi.
